// File: rtl/mem_arb_pkg.sv
// Shared types for the two-port memory arbiter: default widths, FSM state
// encoding and the latched request record.
package mem_arb_pkg;

  localparam int ADDR_W_DEF = 4;
  localparam int DATA_W_DEF = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    CAPT  = 2'd2,
    RESP  = 2'd3
  } state_e;

  typedef struct packed {
    logic                  wr;
    logic [ADDR_W_DEF-1:0] addr;
    logic [DATA_W_DEF-1:0] wdata;
    logic                  port;
  } req_t;

endpackage

// File: rtl/mem_arb_pick.sv
// Winner select for the two request ports. Round-robin when MEM_ARB_RR_EN is
// defined, otherwise fixed priority with port 0 highest.
module mem_arb_pick (
  input  logic [1:0] req_valid_i,
  input  logic       last_grant_i,
  output logic       any_o,
  output logic       winner_o
);

  assign any_o = |req_valid_i;

`ifdef MEM_ARB_RR_EN
  // On contention hand the grant to whichever port did not win last time.
  assign winner_o = (&req_valid_i) ? ~last_grant_i
                                   : (req_valid_i[1] & ~req_valid_i[0]);
`else
  logic unused_last_grant;
  assign unused_last_grant = last_grant_i;
  assign winner_o = req_valid_i[1] & ~req_valid_i[0];
`endif

endmodule

// File: rtl/mem_arb_2p.sv
// Two-port arbiter/sequencer for the 16x32 single-port memory; one request in
// flight at a time. Arbitration mode selected by MEM_ARB_RR_EN (see mem_arb_pick).
//
// state | meaning
// IDLE  | waiting for a request; req_ready to the winner, latch it
// ISSUE | one-cycle memory enable (write or read) with latched addr/data
// CAPT  | read only: memory output valid, captured at end of cycle
// RESP  | one-cycle rsp_valid pulse to the requesting port
module mem_arb_2p
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [1:0]          req_valid,
  input  logic [1:0]          req_wr,
  input  logic [2*ADDR_W-1:0] req_addr,
  input  logic [2*DATA_W-1:0] req_wdata,
  output logic [1:0]          req_ready,
  output logic [1:0]          rsp_valid,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic [DATA_W-1:0]   mem_d_in,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic                mem_en_wr,
  output logic                mem_en_rd,
  input  logic [DATA_W-1:0]   mem_d_out
);

  state_e              state_q, state_d;
  req_t                req_q, req_d;
  logic                last_grant_q, last_grant_d;
  logic                en_wr_q, en_wr_d;
  logic                en_rd_q, en_rd_d;
  logic [1:0]          rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;

  logic any_req;
  logic winner;

  mem_arb_pick u_pick (
    .req_valid_i  (req_valid),
    .last_grant_i (last_grant_q),
    .any_o        (any_req),
    .winner_o     (winner)
  );

  always_comb begin
    state_d      = state_q;
    req_d        = req_q;
    last_grant_d = last_grant_q;
    en_wr_d      = 1'b0;
    en_rd_d      = 1'b0;
    rsp_valid_d  = '0;
    rsp_rdata_d  = '0;
    req_ready    = '0;
    unique case (state_q)
      IDLE: begin
        // rst gating keeps ready low while the block is held in reset
        if (any_req && rst) begin
          req_ready[winner] = 1'b1;
          req_d.wr    = req_wr[winner];
          req_d.addr  = winner ? req_addr[2*ADDR_W-1:ADDR_W] : req_addr[ADDR_W-1:0];
          req_d.wdata = winner ? req_wdata[2*DATA_W-1:DATA_W] : req_wdata[DATA_W-1:0];
          req_d.port  = winner;
          last_grant_d = winner;
          en_wr_d     = req_wr[winner];
          en_rd_d     = ~req_wr[winner];
          state_d     = ISSUE;
        end
      end
      ISSUE: begin
        if (req_q.wr) begin
          rsp_valid_d[req_q.port] = 1'b1;
          state_d = RESP;
        end else begin
          state_d = CAPT;
        end
      end
      CAPT: begin
        rsp_valid_d[req_q.port] = 1'b1;
        rsp_rdata_d = mem_d_out;
        state_d     = RESP;
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      req_q        <= '0;
      last_grant_q <= 1'b1;
      en_wr_q      <= 1'b0;
      en_rd_q      <= 1'b0;
      rsp_valid_q  <= '0;
      rsp_rdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      req_q        <= req_d;
      last_grant_q <= last_grant_d;
      en_wr_q      <= en_wr_d;
      en_rd_q      <= en_rd_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_rdata_q  <= rsp_rdata_d;
    end
  end

  assign mem_addr  = req_q.addr;
  assign mem_d_in  = req_q.wdata;
  assign mem_en_wr = en_wr_q;
  assign mem_en_rd = en_rd_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_mem_arb_2p.sv
// Directed bench for mem_arb_2p with a behavioural 16x32 synchronous memory;
// expectations follow the MEM_ARB_RR_EN build setting.
module tb_mem_arb_2p;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [1:0]  req_valid = '0;
  logic [1:0]  req_wr = '0;
  logic [7:0]  req_addr = '0;
  logic [63:0] req_wdata = '0;
  logic [1:0]  req_ready, rsp_valid;
  logic [31:0] rsp_rdata, mem_d_in;
  logic [31:0] mem_d_out = '0;
  logic [3:0]  mem_addr;
  logic        mem_en_wr, mem_en_rd;
  logic [31:0] mem [16];

  int total = 0;
  int bad = 0;

  mem_arb_2p dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_wr    (req_wr),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .mem_d_in  (mem_d_in),
    .mem_addr  (mem_addr),
    .mem_en_wr (mem_en_wr),
    .mem_en_rd (mem_en_rd),
    .mem_d_out (mem_d_out)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_en_wr) mem[mem_addr] <= mem_d_in;
    if (mem_en_rd) mem_d_out <= mem[mem_addr];
  end

  task automatic cyc();
    @(posedge clk);
    #3;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int p, input logic wr, input logic [3:0] a, input logic [31:0] d);
    req_valid[p] = 1'b1;
    req_wr[p] = wr;
    req_addr[p*4 +: 4] = a;
    req_wdata[p*32 +: 32] = d;
  endtask

  logic [11:0] rdy_v, rd_v, rsp_v;
  logic        coinc;
  logic [7:0]  grants;
  logic [1:0]  others;
  logic [1:0]  rsp_seen;
  logic [7:0]  exp_grants;
  logic [1:0]  exp_second;
  logic [31:0] exp_mem2;

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = '0;
`ifdef MEM_ARB_RR_EN
    exp_grants = 8'b10_01_10_01;
    exp_second = 2'b10;
    exp_mem2   = 32'h3333_3333;
`else
    exp_grants = 8'b01_01_01_01;
    exp_second = 2'b01;
    exp_mem2   = 32'h2222_2222;
`endif

    // reset state
    cyc(); cyc();
    chk("rst_ready", req_ready, 2'b00);
    chk("rst_rsp_valid", rsp_valid, 2'b00);
    chk("rst_rdata", rsp_rdata, 32'h0);
    chk("rst_en_wr", mem_en_wr, 1'b0);
    chk("rst_en_rd", mem_en_rd, 1'b0);
    chk("rst_addr", mem_addr, 4'h0);
    chk("rst_d_in", mem_d_in, 32'h0);
    rst = 1'b1;

    // read of unwritten addr 15
    drive(0, 1'b0, 4'd15, 32'h0);
    #1 chk("rd15_ready", req_ready, 2'b01);
    cyc();
    req_valid = '0;
    chk("rd15_en_rd", mem_en_rd, 1'b1);
    chk("rd15_en_wr", mem_en_wr, 1'b0);
    chk("rd15_addr", mem_addr, 4'd15);
    cyc();
    chk("rd15_capt_rsp", rsp_valid, 2'b00);
    chk("rd15_capt_en_rd", mem_en_rd, 1'b0);
    cyc();
    chk("rd15_rsp", rsp_valid, 2'b01);
    chk("rd15_rdata", rsp_rdata, 32'h0);
    cyc();

    // port 0 write addr 3, then port 1 read addr 3
    drive(0, 1'b1, 4'd3, 32'hDEAD_BEEF);
    #1 chk("wr3_ready", req_ready, 2'b01);
    cyc();
    req_valid = '0;
    chk("wr3_en_wr", mem_en_wr, 1'b1);
    chk("wr3_en_rd", mem_en_rd, 1'b0);
    chk("wr3_addr", mem_addr, 4'd3);
    chk("wr3_d_in", mem_d_in, 32'hDEAD_BEEF);
    chk("wr3_issue_ready", req_ready, 2'b00);
    cyc();
    chk("wr3_rsp", rsp_valid, 2'b01);
    chk("wr3_rsp_rdata", rsp_rdata, 32'h0);
    chk("wr3_resp_en_wr", mem_en_wr, 1'b0);
    drive(1, 1'b0, 4'd3, 32'h0);
    #1 chk("rd3_ready_in_resp", req_ready, 2'b00);
    cyc();
    chk("rd3_idle_rsp", rsp_valid, 2'b00);
    chk("rd3_ready", req_ready, 2'b10);
    cyc();
    req_valid = '0;
    chk("rd3_en_rd", mem_en_rd, 1'b1);
    chk("rd3_addr", mem_addr, 4'd3);
    cyc();
    chk("rd3_capt_rsp", rsp_valid, 2'b00);
    cyc();
    chk("rd3_rsp", rsp_valid, 2'b10);
    chk("rd3_rdata", rsp_rdata, 32'hDEAD_BEEF);
    cyc();
    chk("rd3_after_rsp", rsp_valid, 2'b00);
    chk("rd3_after_rdata", rsp_rdata, 32'h0);

    // back-to-back reads on port 0
    drive(0, 1'b0, 4'd15, 32'h0);
    coinc = 1'b0;
    #1;
    for (int i = 0; i < 12; i++) begin
      rdy_v[i] = req_ready[0];
      rd_v[i]  = mem_en_rd;
      rsp_v[i] = rsp_valid[0];
      coinc    = coinc | (mem_en_wr & mem_en_rd);
      cyc();
    end
    req_valid = '0;
    chk("b2b_ready_pattern", rdy_v, 12'h111);
    chk("b2b_en_rd_pattern", rd_v, 12'h222);
    chk("b2b_rsp_pattern", rsp_v, 12'h888);
    chk("b2b_no_coincident_en", coinc, 1'b0);

    // port 1 request arriving during CAPT of a port 0 read
    drive(0, 1'b0, 4'd3, 32'h0);
    #1 chk("capt_p0_ready", req_ready, 2'b01);
    cyc();
    req_valid = '0;
    cyc();
    drive(1, 1'b1, 4'd2, 32'h2222_2222);
    #1 chk("capt_p1_ready", req_ready, 2'b00);
    cyc();
    chk("resp_p1_ready", req_ready, 2'b00);
    chk("capt_p0_rsp", rsp_valid, 2'b01);
    chk("capt_p0_rdata", rsp_rdata, 32'hDEAD_BEEF);
    cyc();
    chk("idle_p1_ready", req_ready, 2'b10);
    cyc();
    req_valid = '0;
    chk("p1_wr_en_wr", mem_en_wr, 1'b1);
    chk("p1_wr_addr", mem_addr, 4'd2);
    chk("p1_wr_d_in", mem_d_in, 32'h2222_2222);
    cyc();
    chk("p1_wr_rsp", rsp_valid, 2'b10);
    cyc();

    // both ports writing continuously
    drive(0, 1'b1, 4'd1, 32'h1111_1111);
    drive(1, 1'b1, 4'd2, 32'h3333_3333);
    others = '0;
    grants = '0;
    #1;
    for (int i = 0; i < 12; i++) begin
      if (i % 3 == 0) grants[(i/3)*2 +: 2] = req_ready;
      else others = others | req_ready;
      cyc();
    end
    req_valid = '0;
    chk("contend_grants", grants, exp_grants);
    chk("contend_no_extra_ready", others, 2'b00);
    chk("contend_mem1", mem[1], 32'h1111_1111);
    chk("contend_mem2", mem[2], exp_mem2);

    // reset asserted during CAPT of a read
    drive(0, 1'b0, 4'd3, 32'h0);
    #1 chk("rstmid_ready", req_ready, 2'b01);
    cyc();
    req_valid = '0;
    cyc();
    rst = 1'b0;
    #1;
    chk("rstmid_rsp_valid", rsp_valid, 2'b00);
    chk("rstmid_en_rd", mem_en_rd, 1'b0);
    chk("rstmid_en_wr", mem_en_wr, 1'b0);
    chk("rstmid_addr", mem_addr, 4'h0);
    chk("rstmid_d_in", mem_d_in, 32'h0);
    chk("rstmid_rdata", rsp_rdata, 32'h0);
    cyc(); cyc();
    rst = 1'b1;
    rsp_seen = '0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      rsp_seen = rsp_seen | rsp_valid;
    end
    chk("rstmid_no_rsp", rsp_seen, 2'b00);
    drive(0, 1'b0, 4'd15, 32'h0);
    drive(1, 1'b0, 4'd3, 32'h0);
    #1 chk("post_rst_first_grant", req_ready, 2'b01);
    cyc(); cyc(); cyc();
    chk("post_rst_rsp", rsp_valid, 2'b01);
    cyc();
    chk("post_rst_second_grant", req_ready, exp_second);
    cyc();
    req_valid = '0;
    cyc(); cyc(); cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_arb_2p.md
# mem_arb_2p

Two-port arbiter and sequencer for the 16x32 single-port memory (mem_16x32). Accepts read/write requests from two independent requesters over a valid/ready handshake, grants one at a time (round-robin or fixed priority), drives the memory's d_in/addr/en_wr/en_rd, captures read data and returns a one-cycle response pulse to the granted requester. It sits between the memory and its clients, one level up in the memory subsystem top, which instantiates both.

## Interface
- ADDR_W, 4, memory address width (16 words)
- DATA_W, 32, memory data width
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- req_valid  in  2  per-port request valid (bit 0 = port 0)
- req_wr  in  2  per-port 1 = write, 0 = read
- req_addr  in  2xADDR_W  per-port address
- req_wdata  in  2xDATA_W  per-port write data
- req_ready  out  2  per-port accept; request transfers when valid & ready
- rsp_valid  out  2  per-port one-cycle completion pulse (reads and writes)
- rsp_rdata  out  DATA_W  read data, valid with rsp_valid of a read; 0 otherwise
- mem_d_in  out  DATA_W  to memory d_in
- mem_addr  out  ADDR_W  to memory addr
- mem_en_wr  out  1  to memory en_wr
- mem_en_rd  out  1  to memory en_rd
- mem_d_out  in  DATA_W  from memory d_out

## Operation
- FSM states: IDLE, ISSUE, CAPT, RESP.
- IDLE: if any req_valid, pick winner, assert req_ready[winner] (combinational, only in IDLE, only to winner); latch wr/addr/wdata/port; go ISSUE. No valid -> stay IDLE.
- ISSUE: drive mem_en_wr (write) or mem_en_rd (read) for exactly one cycle with latched addr/data. Write -> RESP; read -> CAPT.
- CAPT: memory enables low; sample mem_d_out into rdata register at end of cycle; go RESP.
- RESP: rsp_valid[port]=1 for one cycle; rsp_rdata = captured data (read) or 0 (write); go IDLE.
- mem_en_wr and mem_en_rd never high together; both low outside ISSUE. mem_addr/mem_d_in hold last latched values when idle.
- Loser's request is not accepted; it must hold valid and is served in a later IDLE. Requests presented outside IDLE are ignored (ready=0).
- Requester may drop valid before ready without effect.
- No response backpressure: requester must take rsp_valid when it pulses.

## Timing
- Reset (async assert): state IDLE, req_ready=0, rsp_valid=0, rsp_rdata=0, mem_en_wr=0, mem_en_rd=0, mem_addr=0, mem_d_in=0, rdata=0, last_grant=1 (port 0 wins first). In-flight request dropped, no response issued.
- All outputs except req_ready are registered.
- Accept at cycle T (IDLE). Write: mem_en_wr high T+1, rsp_valid T+2. Read: mem_en_rd high T+1, data captured T+2, rsp_valid + rsp_rdata T+3.
- Next accept earliest T+3 after a write, T+4 after a read.
- Read after write to same address by either port returns the new data (strictly serialized).

## Configuration
- MEM_ARB_RR_EN defined: round-robin; if both valid, grant the port not granted last; last_grant updates on every accept.
- Undefined: fixed priority, port 0 always wins when both valid; last_grant unused.
- Single-requester behaviour identical in both builds.

## Structure
- Package mem_arb_pkg: ADDR_W/DATA_W defaults, state enum (IDLE, ISSUE, CAPT, RESP), request struct (wr, addr, wdata, port).
- Sub-module mem_arb_pick: combinational winner select from req_valid and last_grant, RR/fixed compiled via MEM_ARB_RR_EN.

## Test plan
- Reset mid-read (rst low during CAPT) -> all outputs 0, no rsp_valid, next request after release granted normally.
- Port 0 write addr 3 = 0xDEADBEEF, then port 1 read addr 3 -> port 0 rsp_valid at T+2, port 1 rsp_rdata 0xDEADBEEF at T+3 of its accept.
- Both ports valid continuously, writes to addr 1/2 -> RR: grants alternate 0,1,0,1; fixed: port 0 only while it stays valid.
- Read of unwritten addr 15 after reset -> rsp_rdata 0x00000000.
- Back-to-back reads on port 0 -> accepts spaced exactly 4 cycles, mem_en_rd one-cycle pulses, en_wr never coincident.
- Requests on port 1 while FSM in CAPT -> req_ready stays 0 until IDLE, then accepted.
